// File: rtl/priority_resolver_pkg.sv
// Shared definitions for the priority resolver.
// Holds the acknowledge-FSM state encoding, the lowest-priority pointer
// reset value, the spurious level, and a helper that gives a level's
// distance from the highest-priority slot.
package priority_resolver_pkg;

  // Acknowledge sequence states
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPend = 2'd1;
  localparam logic [1:0] StAck1 = 2'd2;

  // LP = 7 after reset, so IR0 has the highest priority
  localparam logic [2:0] LpReset = 3'd7;

  // Level reported when INTA arrives with no candidate
  localparam logic [2:0] SpuriousLevel = 3'd7;

  // Rank 0 is the highest-priority slot (LP+1), rank 7 the lowest (LP).
  function automatic logic [2:0] prio_rank(logic [2:0] level, logic [2:0] lp);
    return level - lp - 3'd1;
  endfunction

endpackage

// File: rtl/prio_select.sv
// Rotating priority selector.
// Picks the highest-priority set bit of vec, scanning from level lp+1
// (highest) round to level lp (lowest).
//   vec   : request vector, one bit per level
//   lp    : lowest-priority level
//   valid : at least one bit of vec is set
//   level : selected level (0 when valid is low)
module prio_select (
  input  logic [7:0] vec,
  input  logic [2:0] lp,
  output logic       valid,
  output logic [2:0] level
);

  logic [2:0] start;
  logic [7:0] rot;
  logic [2:0] offset;

  always_comb begin
    start  = lp + 3'd1;
    // Rotate right so the highest-priority level sits at bit 0
    rot    = 8'({vec, vec} >> start);
    valid  = |vec;
    offset = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) offset = 3'(i);
    end
    level = valid ? start + offset : 3'd0;
  end

endmodule

// File: rtl/priority_resolver.sv
// 8-level interrupt priority resolver with rotating priority.
// Ports:
//   CLK, RESET   : clock and synchronous active-high reset
//   IRR, IMR     : latched requests and mask (1 = masked)
//   ISR          : in-service bits fed back from the ISR register
//   INTA         : one-cycle CPU acknowledge strobe (two per sequence)
//   EOI_NS       : one-cycle non-specific end-of-interrupt strobe
//   ROTATE_EN    : rotate priority on end of interrupt
//   AEOI         : automatic EOI on the second acknowledge
//   VECTOR_BASE  : vector bits T7..T3
//   INT          : interrupt request to CPU
//   interrupt    : one-hot ISR set pulse
//   EOI_CLR      : one-hot ISR clear pulse
//   DATA_OUT     : vector byte, valid with DATA_OE
//   DATA_OE      : one-cycle vector valid
module priority_resolver
  import priority_resolver_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] IRR,
  input  logic [7:0] IMR,
  input  logic [7:0] ISR,
  input  logic       INTA,
  input  logic       EOI_NS,
  input  logic       ROTATE_EN,
  input  logic       AEOI,
  input  logic [4:0] VECTOR_BASE,
  output logic       INT,
  output logic [7:0] interrupt,
  output logic [7:0] EOI_CLR,
  output logic [7:0] DATA_OUT,
  output logic       DATA_OE
);

  logic [1:0] state_q, state_d;
  logic [2:0] lp_q, lp_d;
  logic [2:0] w_q, w_d;
  logic       spurious_q, spurious_d;
  logic       int_q, int_d;
  logic [7:0] interrupt_q, interrupt_d;
  logic [7:0] eoi_clr_q, eoi_clr_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_oe_q, data_oe_d;

  logic [7:0] req_vec;
  logic       req_valid, isr_valid, cand;
  logic [2:0] req_level, isr_level;

  assign req_vec = IRR & ~IMR;

  prio_select u_req_sel (
    .vec   (req_vec),
    .lp    (lp_q),
    .valid (req_valid),
    .level (req_level)
  );

  prio_select u_isr_sel (
    .vec   (ISR),
    .lp    (lp_q),
    .valid (isr_valid),
    .level (isr_level)
  );

  // Only the best request matters: if it does not beat the in-service
  // level, no lower-priority request can either.
  assign cand = req_valid &&
                (!isr_valid || (prio_rank(req_level, lp_q) < prio_rank(isr_level, lp_q)));

  always_comb begin
    state_d     = state_q;
    lp_d        = lp_q;
    w_d         = w_q;
    spurious_d  = spurious_q;
    int_d       = 1'b0;
    interrupt_d = 8'h00;
    eoi_clr_d   = 8'h00;
    data_out_d  = 8'h00;
    data_oe_d   = 1'b0;

    // Non-specific EOI is honoured in every state
    if (EOI_NS && isr_valid) begin
      eoi_clr_d = 8'b1 << isr_level;
      if (ROTATE_EN) lp_d = isr_level;
    end

    case (state_q)
      StIdle: begin
        if (cand) begin
          state_d = StPend;
          int_d   = 1'b1;
        end
      end
      StPend: begin
        if (INTA) begin
          state_d    = StAck1;
          spurious_d = !cand;
          w_d        = cand ? req_level : SpuriousLevel;
          if (cand) interrupt_d = 8'b1 << req_level;
        end else if (cand) begin
          int_d = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StAck1: begin
        if (INTA) begin
          state_d    = StIdle;
          data_out_d = {VECTOR_BASE, w_q};
          data_oe_d  = 1'b1;
          if (AEOI && !spurious_q) begin
            eoi_clr_d = eoi_clr_d | (8'b1 << w_q);
            // Assigned after the EOI_NS rotation so the AEOI level wins
            if (ROTATE_EN) lp_d = w_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      lp_q        <= LpReset;
      w_q         <= 3'd0;
      spurious_q  <= 1'b0;
      int_q       <= 1'b0;
      interrupt_q <= 8'h00;
      eoi_clr_q   <= 8'h00;
      data_out_q  <= 8'h00;
      data_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lp_q        <= lp_d;
      w_q         <= w_d;
      spurious_q  <= spurious_d;
      int_q       <= int_d;
      interrupt_q <= interrupt_d;
      eoi_clr_q   <= eoi_clr_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
    end
  end

  assign INT       = int_q;
  assign interrupt = interrupt_q;
  assign EOI_CLR   = eoi_clr_q;
  assign DATA_OUT  = data_out_q;
  assign DATA_OE   = data_oe_q;

endmodule

// File: tb/tb_priority_resolver.sv
// Bench for priority_resolver: directed scenarios plus randomized stimulus,
// every cycle compared against a behavioural model of the resolver.
module tb_priority_resolver;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] IRR, IMR, ISR;
  logic       INTA, EOI_NS, ROTATE_EN, AEOI;
  logic [4:0] VECTOR_BASE;
  logic       INT;
  logic [7:0] interrupt, EOI_CLR, DATA_OUT;
  logic       DATA_OE;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: pointer, acknowledges seen in the current sequence,
  // latched level and whether it was spurious
  int m_lp = 7;
  int m_acks = 0;
  int m_w = 0;
  bit m_spur = 0;
  logic       e_int;
  logic [7:0] e_interrupt, e_eoi, e_dout;
  logic       e_oe;

  priority_resolver dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .IRR         (IRR),
    .IMR         (IMR),
    .ISR         (ISR),
    .INTA        (INTA),
    .EOI_NS      (EOI_NS),
    .ROTATE_EN   (ROTATE_EN),
    .AEOI        (AEOI),
    .VECTOR_BASE (VECTOR_BASE),
    .INT         (INT),
    .interrupt   (interrupt),
    .EOI_CLR     (EOI_CLR),
    .DATA_OUT    (DATA_OUT),
    .DATA_OE     (DATA_OE)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Rank 0 = level LP+1 (highest), rank 7 = level LP (lowest)
  function automatic int rank_of(int lvl, int lp);
    return (lvl - lp + 7) % 8;
  endfunction

  function automatic int top_level(logic [7:0] v, int lp);
    for (int k = 1; k <= 8; k++) begin
      if (v[(lp + k) % 8]) return (lp + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_step();
    int  r, h, new_lp;
    bit  cand;
    e_interrupt = 8'h00;
    e_eoi       = 8'h00;
    e_dout      = 8'h00;
    e_oe        = 1'b0;
    e_int       = 1'b0;
    if (RESET) begin
      m_lp = 7; m_acks = 0; m_w = 0; m_spur = 0;
      return;
    end
    r = top_level(IRR & ~IMR, m_lp);
    h = top_level(ISR, m_lp);
    cand = (r >= 0) && ((h < 0) || (rank_of(r, m_lp) < rank_of(h, m_lp)));
    new_lp = m_lp;
    if (EOI_NS && h >= 0) begin
      e_eoi = 8'(1 << h);
      if (ROTATE_EN) new_lp = h;
    end
    if (m_acks == 0) begin
      if (cand) begin
        m_acks = 1;
        e_int = 1'b1;
      end
    end else if (m_acks == 1) begin
      if (INTA) begin
        m_acks = 2;
        m_spur = !cand;
        m_w = cand ? r : 7;
        if (cand) e_interrupt = 8'(1 << r);
      end else if (cand) begin
        e_int = 1'b1;
      end else begin
        m_acks = 0;
      end
    end else if (INTA) begin
      m_acks = 0;
      e_oe = 1'b1;
      e_dout = {VECTOR_BASE, 3'(m_w)};
      if (AEOI && !m_spur) begin
        e_eoi = e_eoi | 8'(1 << m_w);
        if (ROTATE_EN) new_lp = m_w;
      end
    end
    m_lp = new_lp;
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    check_eq("int", INT, e_int);
    check_eq("interrupt", interrupt, e_interrupt);
    check_eq("eoi_clr", EOI_CLR, e_eoi);
    check_eq("data_out", DATA_OUT, e_dout);
    check_eq("data_oe", DATA_OE, e_oe);
  endtask

  task automatic drive(input logic [7:0] irr, input logic [7:0] isr, input logic inta,
                       input logic eoi, input logic rot, input logic aeoi);
    IRR = irr; ISR = isr; INTA = inta; EOI_NS = eoi; ROTATE_EN = rot; AEOI = aeoi;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    IMR = 8'h00;
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    IMR = 8'h00;
    VECTOR_BASE = 5'h08;
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Scenario 1: basic two-INTA sequence
    do_reset();
    check_eq("rst_int", INT, 8'h00);
    check_eq("rst_oe", DATA_OE, 8'h00);
    drive(8'h24, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("s1_int", INT, 8'h01);
    INTA = 1'b1;
    tick();
    check_eq("s1_interrupt", interrupt, 8'h04);
    check_eq("s1_int_drop", INT, 8'h00);
    INTA = 1'b0;
    tick();
    INTA = 1'b1;
    tick();
    check_eq("s1_vector", DATA_OUT, 8'h42);
    check_eq("s1_oe", DATA_OE, 8'h01);
    INTA = 1'b0;
    tick();
    check_eq("s1_oe_once", DATA_OE, 8'h00);

    // Scenario 2: in-service level blocks lower priorities
    do_reset();
    drive(8'h08, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check_eq("s2_blocked", INT, 8'h00);
    IRR = 8'h01;
    tick();
    check_eq("s2_int", INT, 8'h01);
    INTA = 1'b1;
    tick();
    check_eq("s2_winner", interrupt, 8'h01);
    tick();

    // Scenario 3: request withdrawn as the first INTA arrives
    do_reset();
    drive(8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("s3_int", INT, 8'h01);
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("s3_no_pulse", interrupt, 8'h00);
    tick();
    check_eq("s3_spurious", DATA_OUT, 8'h47);

    // Scenario 4: rotating EOI moves LP to 3
    do_reset();
    drive(8'h00, 8'h08, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    check_eq("s4_eoi", EOI_CLR, 8'h08);
    drive(8'h11, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("s4_int", INT, 8'h01);
    INTA = 1'b1;
    tick();
    check_eq("s4_winner", interrupt, 8'h10);
    tick();

    // Scenario 5: AEOI clear coincides with the vector
    do_reset();
    drive(8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    INTA = 1'b1;
    tick();
    check_eq("s5_interrupt", interrupt, 8'h80);
    tick();
    check_eq("s5_oe", DATA_OE, 8'h01);
    check_eq("s5_eoi", EOI_CLR, 8'h80);

    // Scenario 6: reset while in the second acknowledge phase
    do_reset();
    drive(8'h40, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    INTA = 1'b1;
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    check_eq("s6_oe", DATA_OE, 8'h00);
    check_eq("s6_eoi", EOI_CLR, 8'h00);
    check_eq("s6_int", INT, 8'h00);
    drive(8'h81, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    INTA = 1'b1;
    tick();
    check_eq("s6_lp7", interrupt, 8'h01);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      RESET = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) IRR = 8'($urandom);
      if ($urandom_range(0, 7) == 0) IMR = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 5) == 0)
        ISR = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
      INTA        = ($urandom_range(0, 2) == 0);
      EOI_NS      = ($urandom_range(0, 7) == 0);
      ROTATE_EN   = ($urandom_range(0, 1) == 0);
      AEOI        = ($urandom_range(0, 1) == 0);
      VECTOR_BASE = 5'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
